sbp_inject_arbiter: RTL and testbench
=====================================

SBP_INJECT_ARBITER -- requirements
Module: sbp_inject_arbiter

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- STAGE_ID_BITS, 6, stage id width.
- LOCATION_BITS, 11, location width.
- RESULT_BITS, 24, result word width.
- MAX_UPD_BURST, 4, consecutive update grants allowed while a lookup waits (1..15).
- DRAIN_CYCLES, 48, pipeline depth in cycles (2 per stage x 24 stages), 1..255.
REQ-002 Clock/reset: clk in 1 pipeline clock; rst in 1 reset, asynchronous, active-high.
REQ-003 Lookup requester:
- lkp_valid_i in 1 lookup request.
- lkp_ready_o out 1 lookup accepted this cycle.
- lkp_ip_addr_i in 32 address to look up.
REQ-004 Update requester:
- upd_valid_i in 1 update request.
- upd_ready_o out 1 update accepted this cycle.
- upd_prefix_i in 32 prefix.
- upd_prefix_len_i in 6 prefix length.
- upd_stage_id_i in STAGE_ID_BITS target stage.
- upd_location_i in LOCATION_BITS target location.
- upd_result_i in RESULT_BITS node word payload.
- upd_commit_i in 1 last beat of an atomic update batch.
REQ-005 Pipeline head outputs, all registered:
- valid_o out 1 beat injected.
- update_o out 1 beat is a write.
- ip_addr_o out 32.
- bit_pos_o out 6.
- stage_id_o out STAGE_ID_BITS.
- location_o out LOCATION_BITS.
- result_o out RESULT_BITS.
- busy_o out 1 high while in DRAIN.

Function
REQ-006 At most one of lkp_ready_o, upd_ready_o SHALL be high in any cycle; ready is combinational from current state, valids and burst counter.
REQ-007 A beat is accepted when valid and ready are both high; the accepted beat SHALL appear on the outputs with valid_o=1 exactly one cycle later.
REQ-008 Lookup beat outputs SHALL be: update_o=0, ip_addr_o=lkp_ip_addr_i, bit_pos_o=0, stage_id_o=1, location_o=0, result_o=0.
REQ-009 Update beat outputs SHALL be: update_o=1, ip_addr_o=upd_prefix_i, bit_pos_o=upd_prefix_len_i, stage_id_o=upd_stage_id_i, location_o=upd_location_i, result_o=upd_result_i.
REQ-010 In a cycle with no accepted beat, valid_o and update_o SHALL be 0, stage_id_o SHALL be 0 (selects no stage), and all other outputs SHALL hold their values.
REQ-011 FSM states: RUN and DRAIN.
REQ-012 RUN arbitration SHALL grant as follows:
- update wins if upd_valid_i and (burst_cnt < MAX_UPD_BURST or !lkp_valid_i);
- otherwise lookup wins if lkp_valid_i.
REQ-013 burst_cnt (4 bits) SHALL update as follows:
- +1 on each update grant, saturating at MAX_UPD_BURST;
- cleared on lookup grant;
- cleared on any cycle with !upd_valid_i.
REQ-014 Accepting an update with upd_commit_i=1 SHALL move the FSM RUN->DRAIN and load drain_cnt=DRAIN_CYCLES.
REQ-015 In DRAIN:
- lkp_ready_o=0; upd_ready_o=0;
- drain_cnt decrements by 1 per cycle;
- at drain_cnt==1 the FSM returns to RUN, and the first new grant is possible in the following cycle;
- busy_o=1.
REQ-016 No lookup SHALL enter the pipeline until DRAIN_CYCLES cycles after the commit beat was injected, so lookups never observe a partially applied batch.
REQ-017 Simultaneous lkp_valid_i and upd_valid_i with burst_cnt==MAX_UPD_BURST SHALL grant the lookup.
REQ-018 Requesters SHALL hold valid and data stable until accepted; the block SHALL NOT drop or duplicate beats.

Reset
REQ-019 While rst is high:
- FSM=RUN; burst_cnt=0; drain_cnt=0;
- valid_o=0; update_o=0; busy_o=0;
- ip_addr_o, bit_pos_o, stage_id_o, location_o, result_o all 0;
- both ready outputs 0.
REQ-020 Reset asserted mid-DRAIN SHALL abort the drain; the first grant is possible in the first cycle after rst deasserts.

Structure
REQ-021 A shared package sbp_pkg SHALL hold STAGE_ID_BITS, LOCATION_BITS, RESULT_BITS, the root stage id constant (1), and the FSM state enum.
REQ-022 No sub-module is required; the burst/drain counters SHALL stay inline.

Verification
REQ-023 Lookup only: lkp_valid_i=1, ip=0x0A000001 -> next cycle valid_o=1, update_o=0, stage_id_o=1, bit_pos_o=0, location_o=0.
REQ-024 Both valid continuously, MAX_UPD_BURST=4 -> grant pattern U,U,U,U,L repeating.
REQ-025 Update with commit=1 at cycle t -> lkp_ready_o=0 and busy_o=1 for cycles t+1..t+48; a pending lookup is granted at t+49.
REQ-026 Idle after an update to stage 5, location 7 -> outputs hold, valid_o=0, stage_id_o=0.
REQ-027 rst pulse at drain_cnt=20 -> busy_o=0 immediately; a pending lookup is granted in the first cycle after rst deasserts.
REQ-028 Random valid/data stimulus for 10k cycles, scoreboard -> every accepted beat appears exactly once, in order, with exact fields.

Source files
------------

// File: rtl/sbp_pkg.sv
// sbp_pkg: shared widths, root stage id and arbiter FSM states
package sbp_pkg;
  localparam int STAGE_ID_BITS = 6;
  localparam int LOCATION_BITS = 11;
  localparam int RESULT_BITS = 24;
  localparam int ROOT_STAGE_ID = 1;
  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;
endpackage

// File: rtl/sbp_inject_arbiter.sv
// sbp_inject_arbiter: arbitrates lookups and update beats into the search pipeline head
module sbp_inject_arbiter
  import sbp_pkg::*;
#(
  parameter int STAGE_ID_BITS = sbp_pkg::STAGE_ID_BITS,
  parameter int LOCATION_BITS = sbp_pkg::LOCATION_BITS,
  parameter int RESULT_BITS = sbp_pkg::RESULT_BITS,
  parameter int MAX_UPD_BURST = 4,
  parameter int DRAIN_CYCLES = 48
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     lkp_valid_i,
  output logic                     lkp_ready_o,
  input  logic [31:0]              lkp_ip_addr_i,
  input  logic                     upd_valid_i,
  output logic                     upd_ready_o,
  input  logic [31:0]              upd_prefix_i,
  input  logic [5:0]               upd_prefix_len_i,
  input  logic [STAGE_ID_BITS-1:0] upd_stage_id_i,
  input  logic [LOCATION_BITS-1:0] upd_location_i,
  input  logic [RESULT_BITS-1:0]   upd_result_i,
  input  logic                     upd_commit_i,
  output logic                     valid_o,
  output logic                     update_o,
  output logic [31:0]              ip_addr_o,
  output logic [5:0]               bit_pos_o,
  output logic [STAGE_ID_BITS-1:0] stage_id_o,
  output logic [LOCATION_BITS-1:0] location_o,
  output logic [RESULT_BITS-1:0]   result_o,
  output logic                     busy_o
);
  state_t state;
  logic [3:0] burst_cnt;
  logic [7:0] drain_cnt;
  logic run, upd_go, lkp_go, burst_full;
  // grants are combinational; a capped update burst yields to a waiting lookup
  always_comb begin
    run = !rst && state == RUN;
    burst_full = burst_cnt >= 4'(MAX_UPD_BURST);
    upd_ready_o = run && upd_valid_i && (!burst_full || !lkp_valid_i);
    lkp_ready_o = run && lkp_valid_i && !upd_ready_o;
    upd_go = upd_valid_i && upd_ready_o;
    lkp_go = lkp_valid_i && lkp_ready_o;
    busy_o = state == DRAIN;
  end
  // a committed batch blocks injection until its last write has left the pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      drain_cnt <= '0;
    end else if (state == RUN) begin
      if (upd_go && upd_commit_i) begin
        state <= DRAIN;
        drain_cnt <= 8'(DRAIN_CYCLES);
      end
    end else begin
      drain_cnt <= drain_cnt - 8'd1;
      if (drain_cnt == 8'd1) state <= RUN;
    end
  end
  // counts back-to-back update grants so lookups are not starved
  always_ff @(posedge clk or posedge rst) begin
    if (rst) burst_cnt <= '0;
    else if (!upd_valid_i || lkp_go) burst_cnt <= '0;
    else if (upd_go && !burst_full) burst_cnt <= burst_cnt + 4'd1;
  end
  // registered pipeline head; idle cycles drop valid and select no stage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      update_o <= 1'b0;
      ip_addr_o <= '0;
      bit_pos_o <= '0;
      stage_id_o <= '0;
      location_o <= '0;
      result_o <= '0;
    end else begin
      valid_o <= upd_go || lkp_go;
      update_o <= upd_go;
      stage_id_o <= upd_go ? upd_stage_id_i : lkp_go ? STAGE_ID_BITS'(ROOT_STAGE_ID) : '0;
      if (upd_go) begin
        ip_addr_o <= upd_prefix_i;
        bit_pos_o <= upd_prefix_len_i;
        location_o <= upd_location_i;
        result_o <= upd_result_i;
      end else if (lkp_go) begin
        ip_addr_o <= lkp_ip_addr_i;
        bit_pos_o <= '0;
        location_o <= '0;
        result_o <= '0;
      end
    end
  end
endmodule

// File: tb/tb_sbp_inject_arbiter.sv
// tb_sbp_inject_arbiter: vector table, drain/reset sequences and random scoreboard run
module tb_sbp_inject_arbiter;
  localparam int SB = 6, LB = 11, RB = 24, MAXB = 4, DRN = 48;
  logic clk = 0, rst = 1;
  logic lv = 0, uv = 0, cm = 0, lr, ur;
  logic [31:0] ip = 0, pfx = 0;
  logic [5:0] len = 0;
  logic [SB-1:0] st = 0;
  logic [LB-1:0] loc = 0;
  logic [RB-1:0] res = 0;
  logic valid_o, update_o, busy_o;
  logic [31:0] ip_addr_o;
  logic [5:0] bit_pos_o;
  logic [SB-1:0] stage_id_o;
  logic [LB-1:0] location_o;
  logic [RB-1:0] result_o;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  sbp_inject_arbiter #(.MAX_UPD_BURST(MAXB), .DRAIN_CYCLES(DRN)) dut (
    .clk(clk), .rst(rst),
    .lkp_valid_i(lv), .lkp_ready_o(lr), .lkp_ip_addr_i(ip),
    .upd_valid_i(uv), .upd_ready_o(ur), .upd_prefix_i(pfx), .upd_prefix_len_i(len),
    .upd_stage_id_i(st), .upd_location_i(loc), .upd_result_i(res), .upd_commit_i(cm),
    .valid_o(valid_o), .update_o(update_o), .ip_addr_o(ip_addr_o), .bit_pos_o(bit_pos_o),
    .stage_id_o(stage_id_o), .location_o(location_o), .result_o(result_o), .busy_o(busy_o)
  );
  typedef struct packed {
    logic u;
    logic [31:0] ip;
    logic [5:0] bp;
    logic [SB-1:0] st;
    logic [LB-1:0] loc;
    logic [RB-1:0] res;
  } beat_t;
  typedef struct {
    logic lv, uv;
    logic [31:0] ip, pfx;
    logic [5:0] len;
    logic [SB-1:0] st;
    logic [LB-1:0] loc;
    logic [RB-1:0] res;
    logic lr, ur;
    logic [80:0] nxt;
  } vec_t;
  vec_t tbl[11];
  beat_t q[$];
  beat_t last, b;
  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  function automatic logic [80:0] ov(input logic v, u, input logic [31:0] a, input logic [5:0] bp,
                                     input logic [SB-1:0] s, input logic [LB-1:0] l, input logic [RB-1:0] r);
    return {v, u, a, bp, s, l, r};
  endfunction
  function automatic logic [80:0] dut_out();
    return {valid_o, update_o, ip_addr_o, bit_pos_o, stage_id_o, location_o, result_o};
  endfunction
  function automatic vec_t mk(input logic l, u, input logic [31:0] a, p, input logic [5:0] n,
                              input logic [SB-1:0] s, input logic [LB-1:0] c, input logic [RB-1:0] r,
                              input logic elr, eur, input logic [80:0] nx);
    vec_t v;
    v.lv = l; v.uv = u; v.ip = a; v.pfx = p; v.len = n; v.st = s; v.loc = c; v.res = r;
    v.lr = elr; v.ur = eur; v.nxt = nx;
    return v;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int cyc, blocked_until, consec;
    logic el, eu;
    logic [80:0] upd_o, lkp_o;
    upd_o = ov(1, 1, 32'h11111111, 8, 2, 3, 24'hABCDEF);
    lkp_o = ov(1, 0, 32'h01020304, 0, 1, 0, 0);
    tbl[0] = mk(1, 0, 32'h0A000001, 0, 0, 0, 0, 0, 1, 0, ov(1, 0, 32'h0A000001, 0, 1, 0, 0));
    tbl[1] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ov(0, 0, 32'h0A000001, 0, 0, 0, 0));
    tbl[2] = mk(0, 1, 0, 32'hC0A80000, 16, 5, 7, 24'h123456, 0, 1, ov(1, 1, 32'hC0A80000, 16, 5, 7, 24'h123456));
    tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ov(0, 0, 32'hC0A80000, 16, 0, 7, 24'h123456));
    for (int i = 4; i < 11; i++)
      tbl[i] = mk(i < 10, 1, 32'h01020304, 32'h11111111, 8, 2, 3, 24'hABCDEF, i == 8, i != 8, i == 8 ? lkp_o : upd_o);
    repeat (2) @(posedge clk);
    #1;
    lv = 1; uv = 1;
    #1;
    chk("reset_ready", {lr, ur}, 2'b00);
    chk("reset_out", {dut_out(), busy_o}, 0);
    step();
    rst = 0; lv = 0; uv = 0;
    for (int i = 0; i < 11; i++) begin
      lv = tbl[i].lv; uv = tbl[i].uv; ip = tbl[i].ip; pfx = tbl[i].pfx; len = tbl[i].len;
      st = tbl[i].st; loc = tbl[i].loc; res = tbl[i].res;
      #1;
      chk($sformatf("vec%0d_ready", i), {lr, ur}, {tbl[i].lr, tbl[i].ur});
      step();
      chk($sformatf("vec%0d_out", i), dut_out(), tbl[i].nxt);
    end
    lv = 0; uv = 0;
    step();
    lv = 1; ip = 32'h0B0B0B0B; uv = 1; cm = 1; pfx = 32'h22220000; len = 16; st = 9; loc = 11; res = 24'h55;
    #1;
    chk("commit_ready", {lr, ur}, 2'b01);
    step();
    chk("commit_beat", dut_out(), ov(1, 1, 32'h22220000, 16, 9, 11, 24'h55));
    uv = 0; cm = 0;
    for (int k = 1; k <= DRN; k++) begin
      chk($sformatf("drain_t%0d", k), {busy_o, lr}, 2'b10);
      step();
    end
    chk("drain_end", {busy_o, lr}, 2'b01);
    step();
    chk("drain_lookup", dut_out(), ov(1, 0, 32'h0B0B0B0B, 0, 1, 0, 0));
    lv = 0;
    step();
    lv = 1; uv = 1; cm = 1;
    step();
    uv = 0; cm = 0;
    repeat (28) step();
    chk("rst_pre_busy", {busy_o, lr}, 2'b10);
    #2 rst = 1;
    #1;
    chk("rst_mid_drain", {busy_o, lr, ur, dut_out()}, 0);
    step();
    rst = 0;
    #1;
    chk("rst_first_grant", lr, 1);
    step();
    chk("rst_lookup_out", dut_out(), ov(1, 0, 32'h0B0B0B0B, 0, 1, 0, 0));
    rst = 1; lv = 0; uv = 0;
    step();
    rst = 0;
    cyc = 0; blocked_until = 0; consec = 0; el = 0; eu = 0; last = '0;
    for (int n = 0; n < 10000; n++) begin
      if (valid_o) begin
        if (q.size() == 0) chk("sb_extra_beat", 1, 0);
        else begin
          b = q.pop_front();
          chk("sb_beat", dut_out(), ov(1, b.u, b.ip, b.bp, b.st, b.loc, b.res));
          last = b;
        end
      end else chk("sb_idle", dut_out(), ov(0, 0, last.ip, last.bp, 0, last.loc, last.res));
      chk("sb_latency", q.size(), 0);
      if (!lv || el) begin
        lv = 1'($urandom_range(0, 1));
        ip = $urandom;
      end
      if (!uv || eu) begin
        uv = $urandom_range(0, 3) != 0;
        pfx = $urandom; len = 6'($urandom); st = SB'($urandom); loc = LB'($urandom);
        res = RB'($urandom); cm = $urandom_range(0, 23) == 0;
      end
      #1;
      eu = cyc >= blocked_until && uv && (consec < MAXB || !lv);
      el = cyc >= blocked_until && lv && !eu;
      chk("rnd_ready", {lr, ur}, {el, eu});
      if (eu) begin
        q.push_back('{1'b1, pfx, len, st, loc, res});
        consec++;
        if (cm) blocked_until = cyc + DRN + 1;
      end
      if (el) begin
        q.push_back('{1'b0, ip, 6'd0, SB'(1), LB'(0), RB'(0)});
        consec = 0;
      end
      if (!uv) consec = 0;
      cyc++;
      @(posedge clk);
      #1;
    end
    if (valid_o && q.size() == 1) begin
      b = q.pop_front();
      chk("sb_last_beat", dut_out(), ov(1, b.u, b.ip, b.bp, b.st, b.loc, b.res));
    end
    chk("sb_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
